// File: rtl/circuito_jogo_param_if.sv
// Game-round bus for circuito_jogo_param: player controls, round status
// and the raw debug buses that feed the board's display decoders.
interface circuito_jogo_param_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              iniciar;
    logic [WIDTH-1:0]  jogada;
    logic              pronto;
    logic              acertou;
    logic              errou;
    logic              timeout;
    logic              db_igual;
    logic              db_iniciar;
    logic              db_tem_jogada;
    logic [ADDR_W-1:0] db_contagem;
    logic [WIDTH-1:0]  db_memoria;
    logic [WIDTH-1:0]  db_jogada;
    logic [3:0]        db_estado;

    // Player / board side: drives controls, observes status and debug
    modport master (
        output iniciar, jogada,
        input  pronto, acertou, errou, timeout,
        input  db_igual, db_iniciar, db_tem_jogada,
        input  db_contagem, db_memoria, db_jogada, db_estado
    );

    // Game block side
    modport slave (
        input  iniciar, jogada,
        output pronto, acertou, errou, timeout,
        output db_igual, db_iniciar, db_tem_jogada,
        output db_contagem, db_memoria, db_jogada, db_estado
    );
endinterface

// File: rtl/circuito_jogo_param.sv
// Parametrised memory game: walks a fixed ROM of DEPTH words, one address per
// player move. A move is taken on the rising edge of |jogada, compared as a
// whole word with the ROM entry, and the round ends on the first mismatch, on
// a move timeout, or after all DEPTH words match.
module circuito_jogo_param #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 0
) (
    input logic                    clock,
    input logic                    reset,
    circuito_jogo_param_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    // State codes are visible on db_estado, so they stay fixed numeric values
    localparam logic [3:0] INICIAL     = 4'h0;
    localparam logic [3:0] PREPARACAO  = 4'h1;
    localparam logic [3:0] ESPERA      = 4'h2;
    localparam logic [3:0] COMPARACAO  = 4'h4;
    localparam logic [3:0] PROXIMO     = 4'h5;
    localparam logic [3:0] FIM_ACERTO  = 4'hA;
    localparam logic [3:0] FIM_ERRO    = 4'hE;
    localparam logic [3:0] FIM_TIMEOUT = 4'hF;

    logic [3:0]        r_estado;
    logic [3:0]        w_prox_estado;
    logic [ADDR_W-1:0] r_endereco;
    logic [WIDTH-1:0]  r_jogada;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_prev_any;

    logic              w_tem_jogada;
    logic              w_igual;
    logic              w_expirou;
    logic [WIDTH-1:0]  w_memoria;
    logic [WIDTH-1:0]  w_rom [DEPTH];

    // ROM: word i is a one-hot walking bit, 1 << (i mod WIDTH)
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam int SH = gi % WIDTH;
        assign w_rom[gi] = {{(WIDTH-1){1'b0}}, 1'b1} << SH;
    end

    assign w_memoria    = w_rom[r_endereco];
    assign w_igual      = (r_jogada == w_memoria);
    assign w_tem_jogada = (|bus.jogada) & ~r_prev_any;
    assign w_expirou    = (TIMEOUT != 0) && (r_to_cnt == TO_LAST);

    // Edge detector memory: any switch high in the previous cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev_any <= 1'b0;
        end else begin
            r_prev_any <= |bus.jogada;
        end
    end

    // Control FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // Next-state decode; a move arriving on the expiry cycle beats the timeout
    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            INICIAL: begin
                if (bus.iniciar) w_prox_estado = PREPARACAO;
            end
            PREPARACAO: begin
                w_prox_estado = ESPERA;
            end
            ESPERA: begin
                if (w_tem_jogada)   w_prox_estado = COMPARACAO;
                else if (w_expirou) w_prox_estado = FIM_TIMEOUT;
            end
            COMPARACAO: begin
                if (!w_igual)                      w_prox_estado = FIM_ERRO;
                else if (r_endereco == ADDR_LAST)  w_prox_estado = FIM_ACERTO;
                else                               w_prox_estado = PROXIMO;
            end
            PROXIMO: begin
                w_prox_estado = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (bus.iniciar) w_prox_estado = PREPARACAO;
            end
            default: begin
                w_prox_estado = INICIAL;
            end
        endcase
    end

    // Datapath: address counter, move register and move timeout counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_endereco <= '0;
            r_jogada   <= '0;
            r_to_cnt   <= '0;
        end else begin
            case (r_estado)
                PREPARACAO: begin
                    r_endereco <= '0;
                    r_jogada   <= '0;
                    r_to_cnt   <= '0;
                end
                ESPERA: begin
                    if (w_tem_jogada) begin
                        r_jogada <= bus.jogada;
                    end else if (!w_expirou && (TIMEOUT != 0)) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                PROXIMO: begin
                    r_endereco <= r_endereco + ADDR_W'(1);
                    r_to_cnt   <= '0;
                end
                default: begin
                    r_endereco <= r_endereco;
                end
            endcase
        end
    end

    // Moore status outputs
    assign bus.pronto  = (r_estado == FIM_ACERTO) || (r_estado == FIM_ERRO) ||
                         (r_estado == FIM_TIMEOUT);
    assign bus.acertou = (r_estado == FIM_ACERTO);
    assign bus.errou   = (r_estado == FIM_ERRO) || (r_estado == FIM_TIMEOUT);
    assign bus.timeout = (r_estado == FIM_TIMEOUT);

    // Raw debug buses
    assign bus.db_igual      = w_igual;
    assign bus.db_iniciar    = bus.iniciar;
    assign bus.db_tem_jogada = w_tem_jogada;
    assign bus.db_contagem   = r_endereco;
    assign bus.db_memoria    = w_memoria;
    assign bus.db_jogada     = r_jogada;
    assign bus.db_estado     = r_estado;
endmodule

// File: tb/tb_circuito_jogo_param.sv
// Bench for circuito_jogo_param: a move table is replayed against a 4x4
// instance without timeout, each move's expected result is queued and
// compared when the FSM leaves COMPARACAO; a second instance with TIMEOUT=20
// covers expiry timing and the move-versus-expiry tie.
module tb_circuito_jogo_param;
    localparam int W = 4;
    localparam int D = 4;

    localparam logic [3:0] S_INI  = 4'h0;
    localparam logic [3:0] S_PREP = 4'h1;
    localparam logic [3:0] S_ESP  = 4'h2;
    localparam logic [3:0] S_CMP  = 4'h4;
    localparam logic [3:0] S_PROX = 4'h5;
    localparam logic [3:0] S_OK   = 4'hA;
    localparam logic [3:0] S_ERR  = 4'hE;
    localparam logic [3:0] S_TO   = 4'hF;

    typedef struct {
        logic [3:0]  mv;
        int unsigned hold;
        logic [3:0]  st;
        logic [1:0]  cnt;
        logic [3:0]  mem;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [W-1:0] jogada = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          sb_en = 1'b1;
    int unsigned pulses0 = 0;
    logic [3:0]  prev_st0 = 4'h0;

    vec_t tbl [17];
    vec_t sb_q [$];

    always #5 clock = ~clock;

    circuito_jogo_param_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
    circuito_jogo_param_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

    assign bus0.iniciar = iniciar;
    assign bus0.jogada  = jogada;
    assign bus1.iniciar = iniciar;
    assign bus1.jogada  = jogada;

    circuito_jogo_param #(.WIDTH(W), .DEPTH(D), .TIMEOUT(0)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    circuito_jogo_param #(.WIDTH(W), .DEPTH(D), .TIMEOUT(20)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard consumer: the cycle after COMPARACAO carries the move result
    always @(negedge clock) begin
        vec_t e;
        if (bus0.db_tem_jogada) pulses0++;
        if (sb_en && prev_st0 == S_CMP) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: result state %0h with no queued move", bus0.db_estado);
            end else begin
                e = sb_q.pop_front();
                chk("res_estado",   32'(bus0.db_estado),   32'(e.st));
                chk("res_contagem", 32'(bus0.db_contagem), 32'(e.cnt));
                chk("res_jogada",   32'(bus0.db_jogada),   32'(e.mv));
                chk("res_memoria",  32'(bus0.db_memoria),  32'(e.mem));
                chk("res_pronto",   32'(bus0.pronto),  32'(e.st == S_OK || e.st == S_ERR || e.st == S_TO));
                chk("res_acertou",  32'(bus0.acertou), 32'(e.st == S_OK));
                chk("res_errou",    32'(bus0.errou),   32'(e.st == S_ERR || e.st == S_TO));
                chk("res_timeout",  32'(bus0.timeout), 32'(0));
            end
        end
        prev_st0 = bus0.db_estado;
    end

    task automatic apply_row(input int unsigned i);
        sb_q.push_back(tbl[i]);
        jogada = tbl[i].mv;
        repeat (tbl[i].hold) tick();
        jogada = '0;
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'(0));
    endtask

    task automatic start_round();
        iniciar = 1'b1;
        #1;
        chk("db_iniciar", 32'(bus0.db_iniciar), 32'(1));
        tick();
        chk("start_prep", 32'(bus0.db_estado), 32'(S_PREP));
        iniciar = 1'b0;
        tick();
        chk("start_espera",   32'(bus0.db_estado),   32'(S_ESP));
        chk("start_contagem", 32'(bus0.db_contagem), 32'(0));
        chk("start_errou",    32'(bus0.errou),       32'(0));
        chk("start_pronto",   32'(bus0.pronto),      32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned p0;

        tbl[0]  = '{4'h1, 3,  S_PROX, 2'd0, 4'h1};
        tbl[1]  = '{4'h2, 3,  S_PROX, 2'd1, 4'h2};
        tbl[2]  = '{4'h4, 3,  S_PROX, 2'd2, 4'h4};
        tbl[3]  = '{4'h8, 3,  S_OK,   2'd3, 4'h8};
        tbl[4]  = '{4'h1, 3,  S_PROX, 2'd0, 4'h1};
        tbl[5]  = '{4'h4, 3,  S_ERR,  2'd1, 4'h2};
        tbl[6]  = '{4'h3, 3,  S_ERR,  2'd0, 4'h1};
        tbl[7]  = '{4'h1, 3,  S_PROX, 2'd0, 4'h1};
        tbl[8]  = '{4'h2, 3,  S_PROX, 2'd1, 4'h2};
        tbl[9]  = '{4'h4, 3,  S_PROX, 2'd2, 4'h4};
        tbl[10] = '{4'h8, 3,  S_OK,   2'd3, 4'h8};
        tbl[11] = '{4'h1, 10, S_PROX, 2'd0, 4'h1};
        tbl[12] = '{4'h2, 3,  S_PROX, 2'd1, 4'h2};
        tbl[13] = '{4'h4, 3,  S_PROX, 2'd2, 4'h4};
        tbl[14] = '{4'h8, 3,  S_OK,   2'd3, 4'h8};
        tbl[15] = '{4'h1, 3,  S_PROX, 2'd0, 4'h1};
        tbl[16] = '{4'h2, 3,  S_PROX, 2'd1, 4'h2};

        // Reset state
        #12;
        chk("rst_estado",   32'(bus0.db_estado),   32'(S_INI));
        chk("rst_contagem", 32'(bus0.db_contagem), 32'(0));
        chk("rst_jogada",   32'(bus0.db_jogada),   32'(0));
        chk("rst_memoria",  32'(bus0.db_memoria),  32'(1));
        chk("rst_pronto",   32'(bus0.pronto),      32'(0));
        reset = 1'b1;
        tick();
        tick();
        chk("idle_estado", 32'(bus0.db_estado), 32'(S_INI));

        // Full correct round
        start_round();
        for (int unsigned i = 0; i < 4; i++) apply_row(i);
        tick();
        chk("ok_hold_estado",  32'(bus0.db_estado),   32'(S_OK));
        chk("ok_hold_acertou", 32'(bus0.acertou),     32'(1));
        chk("ok_hold_cnt",     32'(bus0.db_contagem), 32'(3));

        // Mismatch on second move
        start_round();
        for (int unsigned i = 4; i < 6; i++) apply_row(i);
        tick();
        chk("err_hold_estado", 32'(bus0.db_estado),  32'(S_ERR));
        chk("err_hold_jog",    32'(bus0.db_jogada),  32'(4));
        chk("err_hold_mem",    32'(bus0.db_memoria), 32'(2));

        // Multi-bit move 0011 against 0001
        start_round();
        apply_row(6);

        // Restart from FIM_ERRO, then a full correct round
        start_round();
        for (int unsigned i = 7; i < 11; i++) apply_row(i);

        // Held move registers once; address steps by one
        start_round();
        p0 = pulses0;
        apply_row(11);
        chk("hold_pulses",   32'(pulses0 - p0),     32'(1));
        chk("hold_contagem", 32'(bus0.db_contagem), 32'(1));
        apply_row(12);
        chk("second_pulses", 32'(pulses0 - p0),     32'(2));
        for (int unsigned i = 13; i < 15; i++) apply_row(i);

        // Asynchronous reset mid-round
        start_round();
        apply_row(15);
        apply_row(16);
        chk("pre_rst_cnt", 32'(bus0.db_contagem), 32'(2));
        #3;
        reset = 1'b0;
        #1;
        chk("arst_estado",   32'(bus0.db_estado),   32'(S_INI));
        chk("arst_contagem", 32'(bus0.db_contagem), 32'(0));
        chk("arst_jogada",   32'(bus0.db_jogada),   32'(0));
        chk("arst_memoria",  32'(bus0.db_memoria),  32'(1));
        chk("arst_estado1",  32'(bus1.db_estado),   32'(S_INI));
        #2;
        reset = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", 32'(bus0.db_estado), 32'(S_INI));

        // Timeout instance
        sb_en = 1'b0;
        start_round();
        n = 0;
        while (bus1.db_estado != S_TO && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles",  32'(n),             32'(20));
        chk("to_timeout", 32'(bus1.timeout),  32'(1));
        chk("to_errou",   32'(bus1.errou),    32'(1));
        chk("to_pronto",  32'(bus1.pronto),   32'(1));
        chk("to_acertou", 32'(bus1.acertou),  32'(0));
        chk("no_to_dut0", 32'(bus0.db_estado), 32'(S_ESP));

        iniciar = 1'b1;
        tick();
        chk("to_restart",   32'(bus1.db_estado), 32'(S_PREP));
        chk("ign_iniciar",  32'(bus0.db_estado), 32'(S_ESP));
        iniciar = 1'b0;
        tick();
        chk("to_espera", 32'(bus1.db_estado), 32'(S_ESP));
        repeat (19) tick();
        jogada = 4'h1;
        tick();
        chk("tie_move_wins", 32'(bus1.db_estado), 32'(S_CMP));
        jogada = '0;
        tick();
        chk("tie_proximo", 32'(bus1.db_estado), 32'(S_PROX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/circuito_jogo_param.md
Name: circuito_jogo_param

Overview:
- Parametrised successor of the single-pass compare circuit.
- Walks an internal ROM of DEPTH words of WIDTH bits, one address per player move (jogada).
- Each move is captured on its rising edge and compared with the stored word. The run ends on the first mismatch (errou), after a move timeout (timeout), or after all DEPTH words match (acertou).
- Top-level game block: control FSM, edge detector, move register, address counter, timeout counter and ROM, with raw debug buses for the board's display decoders.

Parameters:
- WIDTH, 4, bits per move/ROM word (≥2)
- DEPTH, 16, number of ROM words / moves per round (≥2)
- TIMEOUT, 0, max cycles waiting for a move; 0 disables timeout
- ADDR_W (localparam), clog2(DEPTH), address/counter width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately
- iniciar  in  1  start request, synchronous level
- jogada  in  WIDTH  player switches, synchronous to clock
- pronto  out  1  run finished (any end state)
- acertou  out  1  all DEPTH moves matched
- errou  out  1  mismatch or timeout
- timeout  out  1  run ended by timeout
- db_igual  out  1  move register == ROM[address], combinational
- db_iniciar  out  1  copy of iniciar
- db_tem_jogada  out  1  move edge detected this cycle
- db_contagem  out  ADDR_W  current address
- db_memoria  out  WIDTH  ROM[address]
- db_jogada  out  WIDTH  move register
- db_estado  out  4  FSM state code

Behaviour:
- ROM contents are fixed: word i = 1 << (i mod WIDTH). With WIDTH=4 the sequence is 1,2,4,8,1,2,...
- Edge detector:
  - prev_any is a register holding |jogada from the previous cycle.
  - tem_jogada = (|jogada) & ~prev_any.
  - Holding jogada, or changing its value while any bit stays high, does not retrigger.
  - Jogada must return to all-zero before the next move registers.
- FSM states and codes: INICIAL=0, PREPARACAO=1, ESPERA=2, COMPARACAO=4, PROXIMO=5, FIM_ACERTO=A, FIM_ERRO=E, FIM_TIMEOUT=F.
- INICIAL: iniciar=1 → PREPARACAO; otherwise stay.
- PREPARACAO: clears the address counter, move register and timeout counter → ESPERA.
- ESPERA:
  - tem_jogada=1 loads the move register with jogada at this edge → COMPARACAO.
  - Otherwise, if TIMEOUT≠0 and the timeout counter equals TIMEOUT-1 → FIM_TIMEOUT.
  - Otherwise the timeout counter increments and the state stays.
  - If tem_jogada and timeout expiry fall in the same cycle, the move wins.
- COMPARACAO:
  - db_igual=0 → FIM_ERRO.
  - Else address==DEPTH-1 → FIM_ACERTO.
  - Else → PROXIMO.
- PROXIMO: address increments and the timeout counter clears → ESPERA.
- End states hold all status outputs and db buses. iniciar=1 → PREPARACAO (new round); otherwise stay.
- iniciar is ignored in PREPARACAO, ESPERA, COMPARACAO and PROXIMO.
- Latency: with the edge seen in ESPERA at cycle n, the result state is reached at cycle n+2.
- Outputs are Moore, decoded from state:
  - pronto = FIM_*.
  - acertou = FIM_ACERTO.
  - errou = FIM_ERRO | FIM_TIMEOUT.
  - timeout = FIM_TIMEOUT.
- Reset values: state INICIAL, address 0, move register 0, prev_any 0, timeout counter 0.
  - Hence pronto=acertou=errou=timeout=0, db_estado=0, db_contagem=0, db_jogada=0, db_memoria=ROM[0].
- Reset asserted mid-run aborts the run without completing it. Counters are sized so that no wrap occurs before DEPTH-1 / TIMEOUT-1.
- Multi-bit moves are compared as whole words; e.g. 0011 against 0001 is a mismatch.

Test Plan:
1. WIDTH=4, DEPTH=4, TIMEOUT=0; iniciar pulse, then moves 1,2,4,8, each held 3 cycles with 0 between → FIM_ACERTO; acertou=1, pronto=1, errou=0, db_contagem=3, db_estado=A.
2. Same config; moves 1 then 4 → FIM_ERRO after the second move; errou=1, acertou=0, db_contagem=1, db_jogada=4, db_memoria=2, db_estado=E.
3. Move 1 held 10 cycles, then 0, then 2 → exactly one db_tem_jogada pulse per press; db_contagem steps 0→1, never skips to 2.
4. TIMEOUT=20; start, no move → FIM_TIMEOUT exactly 20 cycles after entering ESPERA; timeout=1, errou=1, db_estado=F. Also: a move edge on the expiry cycle → COMPARACAO, not timeout.
5. Reset driven low mid-round (after 2 correct moves, no clock edge) → outputs immediately at reset values; after release, round restarts only on iniciar.
6. From FIM_ERRO, iniciar=1 → PREPARACAO then ESPERA; db_contagem=0, errou=0. A full correct sequence then yields acertou=1.
